btb_writer: RTL and testbench

Update-side controller for the branch target buffer: accepts resolved taken branches from execute, queues them, and writes each into the BTB cell array. Each write either overwrites the cell already holding that PC or allocates a victim cell. The cells themselves only store and compare. This block owns the per-entry valid bitmap, the replacement pointer and the one-hot load strobes, so it is the single writer of the array.

---
 rtl/btb_pkg.sv | 20 ++
 rtl/btb_update_fifo.sv | 66 ++++++
 rtl/btb_writer.sv | 146 ++++++++++++++
 tb/tb_btb_writer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// btb_pkg: shared types and defaults for the BTB update path.
package btb_pkg;

  localparam int BTB_ENTRIES_DEFAULT = 8;
  localparam int BTB_QDEPTH_DEFAULT  = 4;

  // Writer sequencing: look for an existing cell, then strobe one cell.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    WRITE = 2'd2
  } btb_wr_state_e;

  // One resolved taken branch waiting to be written.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
  } btb_update_t;

endpackage

// File: rtl/btb_update_fifo.sv
// btb_update_fifo: small FIFO of resolved branches. Exposes the head and the
// entry behind it so the writer can chain straight into the next probe.
module btb_update_fifo
  import btb_pkg::*;
#(
  parameter int QDEPTH = BTB_QDEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  btb_update_t              push_data,
  input  logic                     pop,
  output btb_update_t              head,
  output btb_update_t              second,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(QDEPTH):0]  count
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0]   CNT_FULL = QDEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  btb_update_t   mem_q [QDEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_next = rd_ptr_q + PTR_ONE;
  assign head    = mem_q[rd_ptr_q];
  assign second  = mem_q[rd_next];
  assign count   = count_q;

  // Payload storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally at QDEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_next;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/btb_writer.sv
// btb_writer: sole writer of the BTB cell array. Queues resolved branches,
// probes the cells for an existing PC, then strobes exactly one cell.
module btb_writer
  import btb_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES_DEFAULT,
  parameter int QDEPTH  = BTB_QDEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               resolve_valid,
  output logic               resolve_ready,
  input  logic [31:0]        resolve_pc,
  input  logic [31:0]        resolve_target,
  input  logic               stall_update,
  input  logic [ENTRIES-1:0] cell_update_match,
  output logic [31:0]        cell_update_addr,
  output logic [31:0]        cell_update_target,
  output logic [ENTRIES-1:0] cell_update,
  output logic [ENTRIES-1:0] entry_valid,
  output logic               busy
);

  localparam int PW = $clog2(ENTRIES);
  localparam int QW = $clog2(QDEPTH);
  localparam logic [QW:0]   CNT_TWO = 2;
  localparam logic [PW-1:0] PTR_ONE = 1;

  btb_wr_state_e      state_q;
  logic [ENTRIES-1:0] hit_q;
  logic [ENTRIES-1:0] entry_valid_q;
  logic [ENTRIES-1:0] entry_valid_d;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      ptr_d;
  logic [31:0]        addr_q;
  logic [31:0]        target_q;

  btb_update_t        fifo_head;
  btb_update_t        fifo_second;
  btb_update_t        fifo_in;
  logic               fifo_full;
  logic               fifo_empty;
  logic [QW:0]        fifo_count;
  logic               fifo_push;
  logic               fifo_pop;

  logic [PW-1:0]      hit_idx;
  logic [PW-1:0]      free_idx;
  logic [PW-1:0]      victim_idx;
  logic [ENTRIES-1:0] victim_oh;
  logic               advance;

  // Ready is forced low while reset is held so nothing is accepted then.
  assign resolve_ready  = rst_n && !fifo_full;
  assign fifo_push      = resolve_valid && resolve_ready;
  assign fifo_pop       = (state_q == WRITE) && rst_n;
  assign fifo_in.pc     = resolve_pc;
  assign fifo_in.target = resolve_target;

  btb_update_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .second    (fifo_second),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Lowest-index hit and lowest-index free entry (scan downward, last wins).
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (hit_q[i])          hit_idx  = PW'(i);
      if (!entry_valid_q[i]) free_idx = PW'(i);
    end
  end

  // Hit wins, then a free slot; only a full table consumes the round-robin pointer.
  assign advance    = !(|hit_q) && (&entry_valid_q);
  assign victim_idx = (|hit_q)          ? hit_idx  :
                      (&entry_valid_q)  ? ptr_q    : free_idx;
  assign ptr_d         = advance ? (ptr_q + PTR_ONE) : ptr_q;
  assign entry_valid_d = entry_valid_q | victim_oh;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_victim_oh
    assign victim_oh[gi] = (victim_idx == PW'(gi));
  end

  // Strobe is qualified by rst_n so a reset landing on WRITE never loads a cell.
  assign cell_update        = ((state_q == WRITE) && rst_n) ? victim_oh : '0;
  assign cell_update_addr   = addr_q;
  assign cell_update_target = target_q;
  assign entry_valid        = entry_valid_q;
  assign busy               = !fifo_empty || (state_q != IDLE);

  // Writer FSM: latch head, capture the probe result, then commit one cell.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hit_q         <= '0;
      entry_valid_q <= '0;
      ptr_q         <= '0;
      addr_q        <= '0;
      target_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty && !stall_update) begin
            addr_q   <= fifo_head.pc;
            target_q <= fifo_head.target;
            state_q  <= PROBE;
          end
        end
        PROBE: begin
          if (stall_update) begin
            state_q <= IDLE;
          end else begin
            hit_q   <= cell_update_match & entry_valid_q;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          entry_valid_q <= entry_valid_d;
          ptr_q         <= ptr_d;
          // The entry behind the head becomes the new head after this pop.
          if ((fifo_count >= CNT_TWO) && !stall_update) begin
            addr_q   <= fifo_second.pc;
            target_q <= fifo_second.target;
            state_q  <= PROBE;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_writer.sv
// tb_btb_writer: directed scenarios plus a randomized phase, all checked
// against a list-level model of the BTB contents and the pending queue.
module tb_btb_writer;
  import btb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        resolve_valid;
  logic        resolve_ready;
  logic [31:0] resolve_pc;
  logic [31:0] resolve_target;
  logic        stall_update;
  logic [7:0]  cell_update_match;
  logic [31:0] cell_update_addr;
  logic [31:0] cell_update_target;
  logic [7:0]  cell_update;
  logic [7:0]  entry_valid;
  logic        busy;

  btb_writer #(
    .ENTRIES (8),
    .QDEPTH  (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .resolve_valid      (resolve_valid),
    .resolve_ready      (resolve_ready),
    .resolve_pc         (resolve_pc),
    .resolve_target     (resolve_target),
    .stall_update       (stall_update),
    .cell_update_match  (cell_update_match),
    .cell_update_addr   (cell_update_addr),
    .cell_update_target (cell_update_target),
    .cell_update        (cell_update),
    .entry_valid        (entry_valid),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell array stand-in: stores a tag on strobe, compares against the broadcast address.
  logic [31:0] cell_pc [8];
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (!rst_n)              cell_pc[i] <= '0;
      else if (cell_update[i]) cell_pc[i] <= cell_update_addr;
    end
  end
  always_comb begin
    cell_update_match = '0;
    for (int i = 0; i < 8; i++) cell_update_match[i] = (cell_pc[i] == cell_update_addr);
  end

  // Reference model: pending list, table contents, replacement pointer.
  btb_update_t exp_q [$];
  logic [7:0]  m_valid;
  logic [31:0] m_pc [8];
  int          m_ptr;

  int          n_checks;
  int          n_errors;
  int          cyc;
  logic        last_accept;
  logic [7:0]  strobe_val [$];
  int          strobe_cyc [$];
  logic [31:0] strobe_tgt [$];
  int          n0;
  int          c1;
  logic [7:0]  e_oh;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: score the current cycle's outputs, then cross the edge.
  task automatic tick();
    int          idx;
    btb_update_t f;
    btb_update_t p;
    logic [7:0]  exp_oh;
    #1;
    chk("entry_valid", entry_valid, m_valid);
    if (cell_update != '0) begin
      strobe_val.push_back(cell_update);
      strobe_cyc.push_back(cyc);
      strobe_tgt.push_back(cell_update_target);
      $display("cyc %0d write cell=%02h pc=%08h target=%08h", cyc, cell_update,
               cell_update_addr, cell_update_target);
      if (exp_q.size() == 0) begin
        chk("strobe_unexpected", cell_update, 0);
      end else begin
        f   = exp_q.pop_front();
        idx = -1;
        for (int i = 0; i < 8; i++) if (idx < 0 && m_valid[i] && m_pc[i] == f.pc) idx = i;
        for (int i = 0; i < 8; i++) if (idx < 0 && !m_valid[i]) idx = i;
        if (idx < 0) begin
          idx   = m_ptr;
          m_ptr = (m_ptr + 1) % 8;
        end
        exp_oh = 8'b1 << idx;
        chk("strobe_cell", cell_update, exp_oh);
        chk("strobe_addr", cell_update_addr, f.pc);
        chk("strobe_target", cell_update_target, f.target);
        m_valid[idx] = 1'b1;
        m_pc[idx]    = f.pc;
      end
    end
    if (resolve_valid && resolve_ready) begin
      p.pc     = resolve_pc;
      p.target = resolve_target;
      exp_q.push_back(p);
      last_accept = 1'b1;
    end else begin
      last_accept = 1'b0;
    end
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_valid = '0;
      m_ptr   = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] tgt);
    int n;
    resolve_valid  = 1'b1;
    resolve_pc     = pc;
    resolve_target = tgt;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_accept && n < 50);
    resolve_valid = 1'b0;
    if (!last_accept) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; last_accept = 1'b0;
    m_valid = '0; m_ptr = 0;
    for (int i = 0; i < 8; i++) m_pc[i] = '0;
    rst_n = 1'b0; resolve_valid = 1'b0; resolve_pc = '0; resolve_target = '0;
    stall_update = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cell_update", cell_update, 0);
    chk("rst_entry_valid", entry_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", resolve_ready, 0);
    chk("rst_addr", cell_update_addr, 0);
    chk("rst_target", cell_update_target, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", resolve_ready, 1);

    // Single push: strobe in cycle 3, address/target held in cycles 2-3
    resolve_valid = 1'b1; resolve_pc = 32'h100; resolve_target = 32'h200;
    tick();
    resolve_valid = 1'b0;
    c1 = cyc;
    chk("c1_busy", busy, 1);
    chk("c1_cell_update", cell_update, 0);
    tick();
    chk("c2_addr", cell_update_addr, 32'h100);
    chk("c2_target", cell_update_target, 32'h200);
    chk("c2_cell_update", cell_update, 0);
    tick();
    chk("c3_cell_update", cell_update, 8'h01);
    chk("c3_addr", cell_update_addr, 32'h100);
    chk("c3_target", cell_update_target, 32'h200);
    chk("c3_entry_valid", entry_valid, 0);
    tick();
    chk("c4_entry_valid", entry_valid, 8'h01);
    chk("c4_cell_update", cell_update, 0);
    chk("c4_busy", busy, 0);

    // Re-push same PC with a new target: rewrites cell 0
    n0 = strobe_val.size();
    push(32'h100, 32'h300);
    wait_idle();
    chk("repush_count", strobe_val.size(), n0 + 1);
    chk("repush_cell", strobe_val[n0], 8'h01);
    chk("repush_target", strobe_tgt[n0], 32'h300);
    chk("repush_valid", entry_valid, 8'h01);

    // Eight more distinct PCs: fill 1..7, then evict entry 0
    n0 = strobe_val.size();
    for (int i = 0; i < 8; i++) push(32'h1000 + 32'(i) * 4, 32'h8000 + 32'(i));
    wait_idle();
    chk("fill_count", strobe_val.size(), n0 + 8);
    for (int i = 0; i < 7; i++) begin
      e_oh = 8'h02 << i;
      chk("fill_cell", strobe_val[n0 + i], e_oh);
    end
    chk("evict_cell", strobe_val[n0 + 7], 8'h01);
    push(32'h2000, 32'h2222);
    wait_idle();
    chk("evict_next_ptr", strobe_val[strobe_val.size() - 1], 8'h02);

    // Stall held: queue fills, no strobes, then drains at 2-cycle spacing
    stall_update = 1'b1;
    n0 = strobe_val.size();
    for (int i = 0; i < 4; i++) push(32'h3000 + 32'(i) * 4, 32'h9000 + 32'(i));
    chk("full_ready", resolve_ready, 0);
    resolve_valid = 1'b1; resolve_pc = 32'h3010; resolve_target = 32'h9004;
    repeat (6) tick();
    chk("stall_no_strobe", strobe_val.size(), n0);
    chk("stall_ready_low", resolve_ready, 0);
    stall_update = 1'b0;
    c1 = 0;
    do begin
      tick();
      c1++;
    end while (!last_accept && c1 < 20);
    resolve_valid = 1'b0;
    if (!last_accept) chk("fifth_push_timeout", 0, 1);
    wait_idle();
    chk("stall_drain_count", strobe_val.size(), n0 + 5);
    chk("stall_first_cell", strobe_val[n0], 8'h04);
    for (int i = 0; i < 3; i++)
      chk("stall_spacing", strobe_cyc[n0 + i + 1] - strobe_cyc[n0 + i], 2);

    // Stall pulse during PROBE: abort, then retry
    n0 = strobe_val.size();
    resolve_valid = 1'b1; resolve_pc = 32'h4444; resolve_target = 32'h5555;
    tick();
    resolve_valid = 1'b0;
    c1 = cyc;
    tick();
    stall_update = 1'b1;
    tick();
    stall_update = 1'b0;
    chk("pulse_no_strobe", cell_update, 0);
    chk("pulse_busy", busy, 1);
    chk("pulse_ready", resolve_ready, 1);
    wait_idle();
    chk("pulse_count", strobe_val.size(), n0 + 1);
    chk("pulse_cycle", strobe_cyc[n0], c1 + 4);
    chk("pulse_cell", strobe_val[n0], 8'h80);

    // Reset landing on the WRITE cycle with three items queued
    stall_update = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h6000 + 32'(i) * 4, 32'h7000 + 32'(i));
    stall_update = 1'b0;
    tick();
    tick();
    chk("pre_rst_strobe", cell_update, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("rst_write_no_strobe", cell_update, 0);
    n0 = strobe_val.size();
    tick();
    chk("rst_write_busy", busy, 0);
    chk("rst_write_valid", entry_valid, 0);
    chk("rst_write_ready", resolve_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_write_ready_after", resolve_ready, 1);
    repeat (4) tick();
    chk("rst_write_no_later_strobe", strobe_val.size(), n0);
    chk("rst_write_idle", busy, 0);

    // Randomized traffic over a small PC pool so hits, fills and evictions mix
    for (int i = 0; i < 400; i++) begin
      resolve_valid  = ($urandom_range(0, 2) != 0);
      resolve_pc     = 32'h4000 + (32'($urandom_range(0, 11)) << 2);
      resolve_target = $urandom;
      stall_update   = ($urandom_range(0, 4) == 0);
      tick();
    end
    resolve_valid = 1'b0;
    stall_update  = 1'b0;
    wait_idle();
    chk("model_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
